// File: rtl/read_requester.sv
// Reduction read front end: latches one command, hands its descriptor to the
// collector, then broadcasts READ requests to every masked port.
package tswitch_pkg;
  localparam int TAG_WIDTH = 8;
endpackage

module read_requester_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic issue,
  input  logic want,
  input  logic ready,
  output logic valid,
  output logic fire,
  output logic issued
);
  // issued sticks once this port has taken the read for the current command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     issued <= 1'b0;
    else if (clr)   issued <= 1'b0;
    else if (fire)  issued <= 1'b1;
  end

  assign valid = issue & want & ~issued;
  assign fire  = valid & ready;
endmodule

module read_requester
  import tswitch_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 32,
  localparam int PORT_BITS = $clog2(NUM_PORTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  input  logic [NUM_PORTS-1:0]  cmd_mask,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [TAG_WIDTH-1:0]  cmd_tag,
  input  logic [PORT_BITS-1:0]  cmd_src_port,
  output logic                  cmd_ready,
  output logic                  pending_valid,
  output logic [NUM_PORTS-1:0]  pending_mask,
  output logic [TAG_WIDTH-1:0]  pending_tag,
  output logic [PORT_BITS-1:0]  pending_src_port,
  input  logic                  pending_ready,
  output logic [NUM_PORTS-1:0]  rd_req_valid,
  output logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic [TAG_WIDTH-1:0]  rd_req_tag,
  input  logic [NUM_PORTS-1:0]  rd_req_ready,
  output logic                  busy,
  output logic                  cmd_err
);
  typedef enum logic [1:0] {IDLE, PEND, ISSUE} state_t;

  state_t                state_q, state_d;
  logic [NUM_PORTS-1:0]  mask_q, issued, fire;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [PORT_BITS-1:0]  src_q;
  logic                  cmd_fire, load, issue_en;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign load     = cmd_fire & (cmd_mask != '0);
  assign issue_en = (state_q == ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      tag_q   <= '0;
      src_q   <= '0;
      cmd_err <= 1'b0;
    end else begin
      state_q <= state_d;
      // zero-mask commands are swallowed and flagged one cycle later
      cmd_err <= cmd_fire & (cmd_mask == '0);
      if (load) begin
        mask_q <= cmd_mask;
        addr_q <= cmd_addr;
        tag_q  <= cmd_tag;
        src_q  <= cmd_src_port;
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
    read_requester_lane u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (load),
      .issue  (issue_en),
      .want   (mask_q[g]),
      .ready  (rd_req_ready[g]),
      .valid  (rd_req_valid[g]),
      .fire   (fire[g]),
      .issued (issued[g])
    );
  end

  always_comb begin
    state_d       = state_q;
    cmd_ready     = 1'b0;
    pending_valid = 1'b0;
    busy          = 1'b1;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (load) state_d = PEND;
      end
      PEND: begin
        pending_valid = 1'b1;
        if (pending_ready) state_d = ISSUE;
      end
      ISSUE: begin
        // exit on the same cycle as the final handshake
        if ((issued | fire) == mask_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pending_mask     = mask_q;
  assign pending_tag      = tag_q;
  assign pending_src_port = src_q;
  assign rd_req_addr      = addr_q;
  assign rd_req_tag       = tag_q;
endmodule

// File: tb/tb_read_requester.sv
// Bench for read_requester: directed scenarios plus random traffic, all checked
// against a transaction-level model of the outstanding reduction.
module tb_read_requester;
  import tswitch_pkg::*;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int PB = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic [NP-1:0] cmd_mask;
  logic [AW-1:0] cmd_addr;
  logic [TAG_WIDTH-1:0] cmd_tag;
  logic [PB-1:0] cmd_src_port;
  logic          cmd_ready;
  logic          pending_valid;
  logic [NP-1:0] pending_mask;
  logic [TAG_WIDTH-1:0] pending_tag;
  logic [PB-1:0] pending_src_port;
  logic          pending_ready;
  logic [NP-1:0] rd_req_valid;
  logic [AW-1:0] rd_req_addr;
  logic [TAG_WIDTH-1:0] rd_req_tag;
  logic [NP-1:0] rd_req_ready;
  logic          busy;
  logic          cmd_err;

  int n_tests = 0;
  int n_fail  = 0;

  read_requester #(.NUM_PORTS(NP), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_mask(cmd_mask), .cmd_addr(cmd_addr),
    .cmd_tag(cmd_tag), .cmd_src_port(cmd_src_port), .cmd_ready(cmd_ready),
    .pending_valid(pending_valid), .pending_mask(pending_mask),
    .pending_tag(pending_tag), .pending_src_port(pending_src_port),
    .pending_ready(pending_ready),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
    .rd_req_tag(rd_req_tag), .rd_req_ready(rd_req_ready),
    .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: one reduction record; "owed" is the set of ports still waiting for a read.
  logic          m_have, m_desc_taken, m_err;
  logic [NP-1:0] m_mask, m_owed;
  logic [AW-1:0] m_addr;
  logic [TAG_WIDTH-1:0] m_tag;
  logic [PB-1:0] m_src;

  task automatic model_reset();
    m_have = 0; m_desc_taken = 0; m_err = 0;
    m_mask = '0; m_owed = '0; m_addr = '0; m_tag = '0; m_src = '0;
  endtask

  task automatic check_outputs();
    logic [NP-1:0] exp_rd;
    exp_rd = (m_have && m_desc_taken) ? m_owed : '0;
    chk("cmd_ready", cmd_ready, !m_have);
    chk("busy", busy, m_have);
    chk("cmd_err", cmd_err, m_err);
    chk("pending_valid", pending_valid, m_have && !m_desc_taken);
    chk("rd_req_valid", rd_req_valid, exp_rd);
    if (m_have && !m_desc_taken) begin
      chk("pending_mask", pending_mask, m_mask);
      chk("pending_tag", pending_tag, m_tag);
      chk("pending_src", pending_src_port, m_src);
    end
    if (exp_rd != '0) begin
      chk("rd_req_addr", rd_req_addr, m_addr);
      chk("rd_req_tag", rd_req_tag, m_tag);
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_err = cmd_valid && !m_have && (cmd_mask == '0);
    if (!m_have) begin
      if (cmd_valid && cmd_mask != '0) begin
        m_have = 1; m_desc_taken = 0;
        m_mask = cmd_mask; m_owed = cmd_mask;
        m_addr = cmd_addr; m_tag = cmd_tag; m_src = cmd_src_port;
      end
    end else if (!m_desc_taken) begin
      if (pending_ready) m_desc_taken = 1;
    end else begin
      m_owed = m_owed & ~rd_req_ready;
      if (m_owed == '0) m_have = 0;
    end
  endtask

  // Check at the falling edge, advance the model, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic v, input logic [NP-1:0] m, input logic [AW-1:0] a,
                           input logic [TAG_WIDTH-1:0] t, input logic [PB-1:0] s);
    cmd_valid = v; cmd_mask = m; cmd_addr = a; cmd_tag = t; cmd_src_port = s;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    pending_ready = 1'b1;
    rd_req_ready = '1;
    drive_cmd(1, 4'b0101, 32'h100, 3, 1);

    // Reset with a command already presented
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_pending_valid", pending_valid, 0);
    chk("rst_rd_req_valid", rd_req_valid, 0);
    chk("rst_pending_mask", pending_mask, 0);
    chk("rst_rd_req_addr", rd_req_addr, 0);
    run(2);
    rst_n = 1'b1;
    tick();
    drive_cmd(0, 0, 0, 0, 0);
    chk("post_rst_accept_busy", busy, 1);
    run(4);

    // Full mask, all ready: descriptor cycle 1, reads cycle 2, idle cycle 3
    drive_cmd(1, 4'b1111, 32'h40, 5, 2);
    tick();
    drive_cmd(0, 0, 0, 0, 0);
    chk("full_c1_pending", {pending_valid, pending_mask}, {1'b1, 4'b1111});
    tick();
    chk("full_c2_rd", rd_req_valid, 4'b1111);
    chk("full_c2_addr", rd_req_addr, 32'h40);
    tick();
    chk("full_c3_idle", {busy, cmd_ready}, 2'b01);
    run(2);

    // Staggered per-port readies
    rd_req_ready = '0;
    drive_cmd(1, 4'b1011, 32'hABCD, 9, 3);
    tick();
    drive_cmd(0, 0, 0, 0, 0);
    tick();
    rd_req_ready = 4'b0001; tick();
    rd_req_ready = 4'b0000; tick();
    rd_req_ready = 4'b1000; tick();
    rd_req_ready = 4'b0000; tick();
    chk("stag_mid_rd", rd_req_valid, 4'b0010);
    tick();
    rd_req_ready = 4'b0010; tick();
    rd_req_ready = 4'b0000;
    chk("stag_idle", busy, 0);
    run(2);

    // Collector back-pressure on the descriptor
    rd_req_ready = '1;
    pending_ready = 1'b0;
    drive_cmd(1, 4'b0110, 32'h2000, 7, 0);
    tick();
    drive_cmd(0, 0, 0, 0, 0);
    run(5);
    chk("bp_still_pending", {pending_valid, rd_req_valid}, {1'b1, 4'b0000});
    pending_ready = 1'b1;
    tick();
    chk("bp_reads_start", rd_req_valid, 4'b0110);
    run(3);

    // Zero-mask command is dropped with an error pulse
    drive_cmd(1, 4'b0000, 32'h55, 1, 1);
    tick();
    drive_cmd(0, 0, 0, 0, 0);
    chk("zero_err_pulse", cmd_err, 1);
    tick();
    chk("zero_err_clear", cmd_err, 0);
    drive_cmd(1, 4'b0010, 32'h66, 2, 2);
    tick();
    drive_cmd(0, 0, 0, 0, 0);
    run(4);

    // Reset asserted while reads are outstanding
    rd_req_ready = '0;
    drive_cmd(1, 4'b0110, 32'h300, 4, 1);
    tick();
    drive_cmd(0, 0, 0, 0, 0);
    run(2);
    chk("pre_rst_rd", rd_req_valid, 4'b0110);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rd", rd_req_valid, 0);
    chk("async_rst_ready", cmd_ready, 1);
    chk("async_rst_pending", pending_valid, 0);
    model_reset();
    run(1);
    rst_n = 1'b1;
    rd_req_ready = '1;
    drive_cmd(1, 4'b1001, 32'h400, 6, 0);
    tick();
    drive_cmd(0, 0, 0, 0, 0);
    tick();
    chk("fresh_rd", rd_req_valid, 4'b1001);
    run(2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive_cmd($urandom_range(0, 1),
                ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom),
                $urandom, TAG_WIDTH'($urandom), PB'($urandom));
      pending_ready = ($urandom_range(0, 2) != 0);
      rd_req_ready  = 4'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/read_requester.md
Name: read_requester

Overview:
- Front end of the reduction read path. Accepts one reduction command: port mask, address, tag and source port.
- Hands a pending descriptor to the response collector, then broadcasts READ requests to every masked port interface.
- Holds exactly one reduction in flight. The next command is accepted only after all reads of the current one are issued.

Parameters:
- NUM_PORTS, 4, number of switch ports; must be >= 2.
- ADDR_WIDTH, 32, read address width.
- TAG_WIDTH, tswitch_pkg value, reduction tag width (package constant, not overridable).
- PORT_BITS, $clog2(NUM_PORTS), local; port index width.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  reduction command valid
- cmd_mask  input  NUM_PORTS  ports to read
- cmd_addr  input  ADDR_WIDTH  read address, same for all ports
- cmd_tag  input  TAG_WIDTH  reduction tag
- cmd_src_port  input  PORT_BITS  requesting port
- cmd_ready  output  1  command accepted when high with cmd_valid
- pending_valid  output  1  descriptor to collector
- pending_mask  output  NUM_PORTS  expected responders
- pending_tag  output  TAG_WIDTH  tag
- pending_src_port  output  PORT_BITS  source port
- pending_ready  input  1  collector accepts descriptor
- rd_req_valid  output  NUM_PORTS  per-port READ request valid
- rd_req_addr  output  ADDR_WIDTH  shared READ address
- rd_req_tag  output  TAG_WIDTH  shared READ tag
- rd_req_ready  input  NUM_PORTS  per-port READ accept
- busy  output  1  state != IDLE
- cmd_err  output  1  one-cycle pulse: zero-mask command dropped

Behaviour:
- Reset: all outputs 0 except cmd_ready=1; state IDLE; internal registers (mask, addr, tag, src, issued_mask) cleared.
- Reset mid-operation: immediate return to IDLE. No request or descriptor is left asserted after rst_n falls.
- States: IDLE, PEND, ISSUE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid with cmd_mask!=0: register mask/addr/tag/src, clear issued_mask, go to PEND next cycle.
  - On cmd_valid with cmd_mask==0: accept and drop the command, pulse cmd_err the following cycle, stay IDLE.
- PEND:
  - pending_valid=1; pending_* driven from registers and held stable until accepted.
  - On pending_ready: go to ISSUE.
  - The descriptor always precedes the reads, so the collector is collecting before responses exist.
- ISSUE:
  - rd_req_valid[i] = mask[i] & ~issued_mask[i]. rd_req_addr and rd_req_tag come from registers.
  - Each port handshakes independently; on rd_req_valid[i] & rd_req_ready[i], set issued_mask[i].
  - Leave ISSUE when (issued_mask | accepted_this_cycle) == mask, in the same cycle as the last handshake.
  - Next state IDLE; cmd_ready=1 on the following cycle.
  - Simultaneous accepts on several ports in one cycle are all recorded. A port that never asserts ready stalls ISSUE indefinitely; there is no timeout.
- cmd_ready is 0 in PEND and ISSUE; the command is registered only on the cmd_valid & cmd_ready cycle.
- Minimum latency, single-bit mask with ready always high:
  - cycle 0 cmd accept, cycle 1 pending, cycle 2 read issue, cycle 3 cmd_ready=1.
  - Sustained throughput is therefore one command per 3 cycles.
- Valid/ready rule: once asserted, a valid (pending or rd_req[i]) and its payload stay stable until the handshake. Ready may toggle freely.
- Tag and address are never modified; no arithmetic beyond mask OR/compare.

Test Plan:
- Reset with cmd_valid=1 held: during reset cmd_ready=1, pending_valid=0, rd_req_valid=0000. After release, command mask=0101, addr=0x100, tag=3 is accepted on the first edge.
- mask=1111, addr=0x40, tag=5, src=2, all readies high:
  - pending {1111,5,2} appears cycle 1.
  - rd_req_valid=1111 with addr 0x40 and tag 5 appears cycle 2.
  - busy=0 and cmd_ready=1 at cycle 3.
- mask=1011, rd_req_ready staggered (port0 cycle 2, port3 cycle 4, port1 cycle 7): rd_req_valid goes 1011 -> 1010 -> 0010 -> 0000. Addr and tag are held stable throughout. IDLE at cycle 8.
- pending_ready held low 5 cycles: pending_valid and payload stable, rd_req_valid=0 throughout, cmd_ready=0. Reads start the cycle after pending_ready rises.
- cmd_mask=0000 with cmd_valid: cmd_err pulses exactly one cycle, no pending or read activity. The next command (mask=0010) is processed normally.
- Assert rst_n=0 during ISSUE with rd_req_valid=0110: all valids drop asynchronously, cmd_ready=1. A fresh command after release issues only its own mask.
